// File: rtl/nn_pkg.sv
// nn_pkg: shared widths, datapath latency and sequencer state encoding
package nn_pkg;
    localparam int DATA_W = 16;
    localparam int NUM_IN = 4;
    localparam int NEURON_LAT = 3;
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, OUT, DONE} state_t;
endpackage

// File: rtl/neuron_layer_sequencer_if.sv
// neuron_layer_sequencer_if: weight-RAM read port and result stream of the layer sequencer
interface neuron_layer_sequencer_if #(
    parameter int DATA_W = nn_pkg::DATA_W,
    parameter int IDX_W = 3
);
    logic w_rd_en;
    logic [IDX_W-1:0] w_addr;
    logic [nn_pkg::NUM_IN*DATA_W-1:0] w_rdata;
    logic res_valid;
    logic res_ready;
    logic [DATA_W-1:0] res_data;
    logic [IDX_W-1:0] res_idx;
    modport master(output w_rd_en, w_addr, res_valid, res_data, res_idx, input w_rdata, res_ready);
    modport slave(input w_rd_en, w_addr, res_valid, res_data, res_idx, output w_rdata, res_ready);
endinterface

// File: rtl/neuron_layer_sequencer.sv
// neuron_layer_sequencer: time-multiplexes one 4-input neuron datapath across a layer's outputs
module neuron_layer_sequencer
    import nn_pkg::*;
#(
    parameter int DATA_W = nn_pkg::DATA_W,
    parameter int NUM_NEURONS = 8,
    parameter int IDX_W = 3,
    parameter int W_BASE = 0,
    parameter int NEURON_LAT = nn_pkg::NEURON_LAT
) (
    input logic clk,
    input logic rst,
    input logic start,
    input logic [NUM_IN*DATA_W-1:0] x_in,
    input logic [DATA_W-1:0] sigma_in,
    output logic busy,
    output logic done,
    output logic [NUM_IN*DATA_W-1:0] n_x,
    output logic [NUM_IN*DATA_W-1:0] n_w,
    output logic [DATA_W-1:0] n_sigma,
    input logic [DATA_W-1:0] n_y,
    neuron_layer_sequencer_if.master bus
);
    localparam int CW = $clog2(NEURON_LAT + 2);
    state_t state, nxt;
    logic [IDX_W-1:0] idx;
    logic [CW-1:0] cnt;
    logic last;
    assign last = idx == IDX_W'(NUM_NEURONS - 1);
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign bus.w_rd_en = state == FETCH;
    assign bus.w_addr = bus.w_rd_en ? IDX_W'(W_BASE) + idx : '0;
    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = start ? FETCH : IDLE;
            FETCH: nxt = ISSUE;
            ISSUE: nxt = WAIT;
            WAIT: nxt = cnt == '0 ? OUT : WAIT;
            OUT: nxt = bus.res_ready ? (last ? DONE : FETCH) : OUT;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            cnt <= '0;
            n_x <= '0;
            n_w <= '0;
            n_sigma <= '0;
            bus.res_valid <= 1'b0;
            bus.res_data <= '0;
            bus.res_idx <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && start) begin
                n_x <= x_in;
                n_sigma <= sigma_in;
                idx <= '0;
            end
            if (state == ISSUE) begin
                n_w <= bus.w_rdata;
                cnt <= CW'(NEURON_LAT);
            end
            // cnt reaching zero means the datapath has had NEURON_LAT edges on stable inputs
            if (state == WAIT) begin
                if (cnt == '0) begin
                    bus.res_data <= n_y;
                    bus.res_idx <= idx;
                    bus.res_valid <= 1'b1;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
            if (state == OUT && bus.res_ready) begin
                bus.res_valid <= 1'b0;
                if (!last) idx <= idx + IDX_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// tb_neuron_layer_sequencer: directed and randomized checks against a behavioural layer model
module tb_neuron_layer_sequencer;
    localparam int NN8 = 8;
    logic clk = 0;
    always #5 clk = ~clk;
    int n_chk = 0, n_fail = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // neuron: sum of Q16 products, passed through only when strictly above sigma
    function automatic logic [15:0] nexp(input logic [63:0] x, input logic [63:0] w, input logic [15:0] s);
        logic [31:0] sum;
        sum = 0;
        for (int k = 0; k < 4; k++) sum += (32'(x[16*k+:16]) * 32'(w[16*k+:16])) >> 16;
        return (sum[15:0] > s) ? sum[15:0] : 16'h0;
    endfunction

    logic rst1, start1, busy1, done1;
    logic [63:0] x1, nx1, nw1;
    logic [15:0] s1, ns1, ny1, a1, b1;
    logic [63:0] mem1 [8];
    neuron_layer_sequencer_if #(.DATA_W(16), .IDX_W(3)) bus1 ();
    neuron_layer_sequencer #(.DATA_W(16), .NUM_NEURONS(1), .IDX_W(3), .W_BASE(5), .NEURON_LAT(3)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .x_in(x1), .sigma_in(s1), .busy(busy1), .done(done1),
        .n_x(nx1), .n_w(nw1), .n_sigma(ns1), .n_y(ny1), .bus(bus1.master));
    always @(posedge clk) begin
        if (bus1.w_rd_en) bus1.w_rdata <= mem1[bus1.w_addr];
        a1 <= nexp(nx1, nw1, ns1);
        b1 <= a1;
        ny1 <= b1;
    end

    logic rst8, start8, busy8, done8;
    logic [63:0] x8, nx8, nw8;
    logic [15:0] s8, ns8, ny8, a8, b8;
    logic [63:0] mem8 [8];
    neuron_layer_sequencer_if #(.DATA_W(16), .IDX_W(3)) bus8 ();
    neuron_layer_sequencer #(.DATA_W(16), .NUM_NEURONS(NN8), .IDX_W(3), .W_BASE(0), .NEURON_LAT(3)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .x_in(x8), .sigma_in(s8), .busy(busy8), .done(done8),
        .n_x(nx8), .n_w(nw8), .n_sigma(ns8), .n_y(ny8), .bus(bus8.master));
    always @(posedge clk) begin
        if (bus8.w_rd_en) bus8.w_rdata <= mem8[bus8.w_addr];
        a8 <= nexp(nx8, nw8, ns8);
        b8 <= a8;
        ny8 <= b8;
    end

    // model: a result appears 6 cycles after each start/handshake; done follows the last handshake
    bit m_run, m_done, m_valid, m_fetch;
    int m_idx, m_t;
    logic [63:0] ex;
    logic [15:0] es, m_y;
    always @(posedge clk) begin
        if (rst8) begin
            m_run = 0; m_done = 0; m_valid = 0; m_fetch = 0; m_idx = 0; ex = 0; es = 0;
        end else begin
            m_fetch = 0;
            if (m_done) m_done = 0;
            else if (!m_run) begin
                if (start8) begin
                    ex = x8; es = s8; m_run = 1; m_idx = 0; m_t = 6; m_fetch = 1;
                end
            end else if (!m_valid) begin
                m_t--;
                if (m_t == 0) begin
                    m_valid = 1;
                    m_y = nexp(ex, mem8[m_idx % 8], es);
                end
            end else if (bus8.res_ready) begin
                m_valid = 0;
                if (m_idx == NN8 - 1) begin
                    m_run = 0; m_done = 1;
                end else begin
                    m_idx++; m_t = 6; m_fetch = 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            chk("busy", busy8, m_run || m_done);
            chk("done", done8, m_done);
            chk("res_valid", bus8.res_valid, m_valid);
            chk("w_rd_en", bus8.w_rd_en, m_fetch);
            if (m_valid) begin
                chk("res_data", bus8.res_data, m_y);
                chk("res_idx", bus8.res_idx, m_idx);
            end
            if (m_fetch) chk("w_addr", bus8.w_addr, m_idx % 8);
            if (m_run) begin
                chk("n_x", nx8, ex);
                chk("n_sigma", ns8, es);
            end
        end
    end

    logic [15:0] qd [$];
    int qi [$];
    always @(negedge clk) begin
        #2;
        if (!rst8 && bus8.res_valid && bus8.res_ready) begin
            qd.push_back(bus8.res_data);
            qi.push_back(int'(bus8.res_idx));
        end
    end

    task automatic run1(input logic [15:0] sigma, input logic [15:0] exp);
        int lat;
        lat = 0;
        @(negedge clk);
        x1 = {4{16'h0100}}; s1 = sigma; start1 = 1;
        @(negedge clk);
        start1 = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #2;
            if (bus1.res_valid) begin
                lat = k;
                break;
            end
        end
        chk("n1_latency", lat, 6);
        chk("n1_res_data", bus1.res_data, exp);
        chk("n1_res_idx", bus1.res_idx, 0);
        @(posedge clk); #2;
        chk("n1_done", done1, 1);
        chk("n1_valid_dropped", bus1.res_valid, 0);
        @(posedge clk); #2;
        chk("n1_done_pulse", done1, 0);
        chk("n1_busy_after", busy1, 0);
    endtask

    task automatic start_run(input logic [63:0] x, input logic [15:0] s);
        @(negedge clk);
        x8 = x; s8 = s; start8 = 1;
        @(negedge clk);
        start8 = 0;
    endtask

    task automatic wait_done8(input int budget);
        bit ok;
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done8) begin
                ok = 1;
                break;
            end
        end
        chk("done_timeout", ok, 1);
        @(negedge clk);
    endtask

    task automatic check_layer();
        chk("n_results", qd.size(), 8);
        for (int i = 0; i < qd.size(); i++) begin
            chk("layer_idx", qi[i], i);
            chk("layer_data", qd[i], 4 * (i + 1));
        end
    endtask

    initial begin
        bit ok;
        rst1 = 1; start1 = 0; x1 = 0; s1 = 0; bus1.res_ready = 1;
        rst8 = 1; start8 = 0; x8 = 0; s8 = 0; bus8.res_ready = 1;
        for (int i = 0; i < 8; i++) begin
            mem1[i] = 0;
            mem8[i] = {4{16'((i + 1) * 16'h0100)}};
        end
        mem1[5] = {4{16'h0100}};
        chk("model_pin_met", nexp({4{16'h0100}}, {4{16'h0100}}, 3), 4);
        chk("model_pin_strict", nexp({4{16'h0100}}, {4{16'h0100}}, 4), 0);
        chk("model_pin_layer", nexp({4{16'h0100}}, {4{16'h0800}}, 0), 32);
        repeat (3) @(negedge clk);
        chk("rst_busy1", busy1, 0);
        chk("rst_valid1", bus1.res_valid, 0);
        chk("rst_busy8", busy8, 0);
        chk("rst_nx8", nx8, 0);
        chk("rst_rden8", bus8.w_rd_en, 0);
        rst1 = 0; rst8 = 0; chk_en = 1;
        run1(16'd3, 16'd4);
        run1(16'd4, 16'd0);
        run1(16'hFFFF, 16'd0);

        qd.delete(); qi.delete();
        start_run({4{16'h0100}}, 16'd0);
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus8.res_valid && bus8.res_idx == 2) begin
                ok = 1;
                break;
            end
        end
        chk("stall_reach", ok, 1);
        bus8.res_ready = 0;
        chk("stall_data", bus8.res_data, 12);
        x8 = {4{16'h0300}}; s8 = 16'd1; start8 = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start8 = 0;
            chk("stall_hold_data", bus8.res_data, 12);
            chk("stall_hold_idx", bus8.res_idx, 2);
        end
        bus8.res_ready = 1;
        wait_done8(200);
        check_layer();

        start_run({$urandom, $urandom}, 16'($urandom));
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (m_run && m_idx == 3 && !m_valid && m_t == 3) begin
                ok = 1;
                break;
            end
        end
        chk("rst_reach", ok, 1);
        rst8 = 1; start8 = 1;
        @(negedge clk);
        rst8 = 0; start8 = 0;
        chk("midrst_busy", busy8, 0);
        chk("midrst_valid", bus8.res_valid, 0);
        chk("midrst_done", done8, 0);
        qd.delete(); qi.delete();
        start_run({4{16'h0100}}, 16'd0);
        wait_done8(200);
        check_layer();

        for (int c = 0; c < 4; c++) begin
            start8 = 0; rst8 = 0; bus8.res_ready = 1;
            ok = 0;
            for (int k = 0; k < 300; k++) begin
                @(negedge clk);
                if (!m_run && !m_done) begin
                    ok = 1;
                    break;
                end
            end
            chk("idle_reach", ok, 1);
            for (int i = 0; i < 8; i++) mem8[i] = {$urandom, $urandom};
            for (int k = 0; k < 700; k++) begin
                @(negedge clk);
                start8 = ($urandom % 6) == 0;
                x8 = {$urandom, $urandom};
                s8 = 16'($urandom);
                bus8.res_ready = ($urandom % 4) != 0;
                rst8 = ($urandom % 250) == 0;
            end
        end
        @(negedge clk);
        rst8 = 0; start8 = 0;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
